// File: rtl/bg_tile_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// bg_tile_fetch_sequencer
//
// Purpose:
//   Walks one scanline of background tiles. For each tile it publishes the
//   pixel row/column the pointer calculator needs, then reads the nametable
//   byte, the attribute byte and both pattern-plane bytes over a single
//   req/ack VRAM read port. The assembled tile is handed to the background
//   shifter through a one-entry valid/ready buffer. While that buffer is
//   full the sequencer does not begin the next tile.
//
// Build option:
//   BG_ATTR_FETCH_EN - when defined, an attribute fetch runs between the
//                      nametable and pattern fetches and tile_attr carries
//                      the selected palette. When undefined, each tile takes
//                      only three fetches and tile_attr is tied to 2'b00.
//
// Parameters:
//   TILES_PER_LINE  tiles fetched per start_line (1..32)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_line, line_row       line start pulse and the pixel row to fetch
//   bg_pt_sel                  background pattern table select
//   fetch_pixel_row/col        pixel coordinate driven to the pointer calc
//   nametable_ptr              nametable address from the pointer calc
//   pattern_table_offset       fine row within the tile from the pointer calc
//   vram_req/addr/ack/rdata    VRAM read port
//   tile_valid/ready           tile buffer handshake
//   tile_pat_lo/hi, tile_attr  assembled tile contents
//   busy                       a line is in progress
//   line_done                  one-cycle pulse after the last tile is taken
// ---------------------------------------------------------------------------
module bg_tile_fetch_sequencer #(
    parameter int TILES_PER_LINE = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_line,
    input  logic [8:0]  line_row,
    input  logic        bg_pt_sel,
    output logic [8:0]  fetch_pixel_row,
    output logic [8:0]  fetch_pixel_col,
    input  logic [15:0] nametable_ptr,
    input  logic [2:0]  pattern_table_offset,
    output logic        vram_req,
    output logic [15:0] vram_addr,
    input  logic        vram_ack,
    input  logic [7:0]  vram_rdata,
    output logic        tile_valid,
    input  logic        tile_ready,
    output logic [7:0]  tile_pat_lo,
    output logic [7:0]  tile_pat_hi,
    output logic [1:0]  tile_attr,
    output logic        busy,
    output logic        line_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NT,
        S_AT,
        S_PLO,
        S_PHI,
        S_OUT
    } state_t;

    localparam logic [5:0] LAST_TILE = 6'(TILES_PER_LINE - 1);

    state_t      state_q;
    state_t      state_d;
    logic        gap_q;
    logic [5:0]  n_q;
    logic [8:0]  row_q;
    logic [7:0]  idx_q;
    logic [7:0]  pat_lo_q;
    logic [7:0]  pat_hi_q;
    logic        line_done_q;
    logic        fetch_ack;
    logic        last_tile;
    logic        tile_accept;
    logic [15:0] pat_addr;

`ifdef BG_ATTR_FETCH_EN
    logic [15:0] at_addr_q;
    logic [2:0]  attr_shift_q;
    logic [1:0]  attr_q;
`endif

    // An ack only counts while a request is actually being driven, so a
    // stray ack during the idle gap or outside a fetch is ignored.
    assign fetch_ack   = vram_req & vram_ack;
    assign last_tile   = (n_q == LAST_TILE);
    assign tile_accept = (state_q == S_OUT) & tile_ready;

    // Both pattern planes share one address; PHI differs only in bit 3.
    assign pat_addr = {3'b000, bg_pt_sel, idx_q, 1'b0, pattern_table_offset};

    assign fetch_pixel_row = row_q;
    assign fetch_pixel_col = {n_q[4:0], 3'b000};
    assign tile_valid      = (state_q == S_OUT);
    assign busy            = (state_q != S_IDLE);
    assign line_done       = line_done_q;
    assign tile_pat_lo     = pat_lo_q;
    assign tile_pat_hi     = pat_hi_q;

`ifdef BG_ATTR_FETCH_EN
    assign tile_attr = attr_q;
`else
    assign tile_attr = 2'b00;
`endif

    // Next-state and VRAM port decode. Request and address are derived
    // straight from the state register, so an asynchronous reset pulls
    // vram_req low immediately. gap_q suppresses the request for the
    // first cycle after every completed fetch, which guarantees the idle
    // cycle between consecutive requests.
    always_comb begin
        state_d   = state_q;
        vram_req  = 1'b0;
        vram_addr = 16'h0000;
        case (state_q)
            S_IDLE: begin
                if (start_line) begin
                    state_d = S_NT;
                end
            end
            S_NT: begin
                vram_req  = ~gap_q;
                vram_addr = nametable_ptr;
                if (fetch_ack) begin
`ifdef BG_ATTR_FETCH_EN
                    state_d = S_AT;
`else
                    state_d = S_PLO;
`endif
                end
            end
`ifdef BG_ATTR_FETCH_EN
            S_AT: begin
                vram_req  = ~gap_q;
                vram_addr = at_addr_q;
                if (fetch_ack) begin
                    state_d = S_PLO;
                end
            end
`endif
            S_PLO: begin
                vram_req  = ~gap_q;
                vram_addr = pat_addr;
                if (fetch_ack) begin
                    state_d = S_PHI;
                end
            end
            S_PHI: begin
                vram_req  = ~gap_q;
                vram_addr = pat_addr | 16'h0008;
                if (fetch_ack) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (tile_ready) begin
                    state_d = last_tile ? S_IDLE : S_NT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register plus the one-cycle gap flag that follows every
    // accepted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= fetch_ack;
        end
    end

    // Line bookkeeping: the row and tile counter are latched only from
    // IDLE, so a start_line that arrives mid-line has no effect. The tile
    // counter advances when a tile leaves the buffer, which also moves the
    // pointer column for the next tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q       <= 9'd0;
            n_q         <= 6'd0;
            line_done_q <= 1'b0;
        end else begin
            line_done_q <= tile_accept & last_tile;
            if (state_q == S_IDLE && start_line) begin
                row_q <= line_row;
                n_q   <= 6'd0;
            end else if (tile_accept && !last_tile) begin
                n_q <= n_q + 6'd1;
            end
        end
    end

    // Fetched bytes are captured only in the cycle the matching ack is
    // accepted. None of these registers can change while the tile is
    // presented, because no fetch state is active during OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= 8'h00;
            pat_lo_q <= 8'h00;
            pat_hi_q <= 8'h00;
        end else if (fetch_ack) begin
            case (state_q)
                S_NT:    idx_q    <= vram_rdata;
                S_PLO:   pat_lo_q <= vram_rdata;
                S_PHI:   pat_hi_q <= vram_rdata;
                default: ;
            endcase
        end
    end

`ifdef BG_ATTR_FETCH_EN
    // Attribute path. The attribute-table address and the quadrant shift
    // are precomputed from the nametable address when the nametable byte
    // arrives; the quadrant is picked by the coarse row bit (nt[6]) and
    // coarse column bit (nt[1]), giving a shift of 0, 2, 4 or 6.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            at_addr_q    <= 16'h0000;
            attr_shift_q <= 3'd0;
            attr_q       <= 2'b00;
        end else if (fetch_ack) begin
            if (state_q == S_NT) begin
                at_addr_q    <= {4'h2, nametable_ptr[11:10], 4'hF,
                                 nametable_ptr[9:7], nametable_ptr[4:2]};
                attr_shift_q <= {nametable_ptr[6], nametable_ptr[1], 1'b0};
            end else if (state_q == S_AT) begin
                attr_q <= 2'(vram_rdata >> attr_shift_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bg_tile_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bg_tile_fetch_sequencer
//
// Self-checking bench for bg_tile_fetch_sequencer. A small VRAM responder
// and pointer-calc stand-in drive the design; an address/data model of the
// fetch sequence predicts every request, and assembled tiles are queued in
// a scoreboard when their last byte is returned and popped when the design
// presents them. A second instance with TILES_PER_LINE=1 shares the inputs
// and must finish its line right after the first tile.
// ---------------------------------------------------------------------------
module tb_bg_tile_fetch_sequencer;

    localparam int TPL = 32;
`ifdef BG_ATTR_FETCH_EN
    localparam int NF    = 4;
    localparam int K_PLO = 2;
`else
    localparam int NF    = 3;
    localparam int K_PLO = 1;
`endif
    localparam int K_PHI = K_PLO + 1;

    localparam int KIND_NT  = 0;
    localparam int KIND_AT  = 1;
    localparam int KIND_PLO = 2;
    localparam int KIND_PHI = 3;

    typedef struct {
        logic [8:0]  row;
        logic        sel;
        logic [15:0] base;
        int          ack_dly;
        int          rdy_dly;
        bit          spurious;
        logic [15:0] exp_nt0;
        logic [15:0] exp_at0;
        int          exp_done;
    } vec_t;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [1:0] attr;
    } tile_t;

    logic        clk;
    logic        rst_n;
    logic        start_line;
    logic [8:0]  line_row;
    logic        bg_pt_sel;
    logic [8:0]  fetch_pixel_row;
    logic [8:0]  fetch_pixel_col;
    logic [15:0] nametable_ptr;
    logic [2:0]  pattern_table_offset;
    logic        vram_req;
    logic [15:0] vram_addr;
    logic        vram_ack;
    logic [7:0]  vram_rdata;
    logic        tile_valid;
    logic        tile_ready;
    logic [7:0]  tile_pat_lo;
    logic [7:0]  tile_pat_hi;
    logic [1:0]  tile_attr;
    logic        busy;
    logic        line_done;

    logic [8:0]  one_pixel_row;
    logic [8:0]  one_pixel_col;
    logic        one_vram_req;
    logic [15:0] one_vram_addr;
    logic        one_tile_valid;
    logic [7:0]  one_pat_lo;
    logic [7:0]  one_pat_hi;
    logic [1:0]  one_attr;
    logic        one_busy;
    logic        one_line_done;

    logic [15:0] nt_base;

    int errors = 0;
    int checks = 0;

    logic [15:0] ov_nt_addr, ov_at_addr;
    logic [7:0]  ov_nt_data, ov_at_data;
    bit          ov_en;

    logic [8:0]  exp_row;
    logic        exp_sel;
    logic [15:0] exp_base;
    int          exp_n, exp_k;
    logic [7:0]  exp_idx, exp_at, exp_lo;
    tile_t       tile_q[$];

    int          ack_dly, rdy_dly, ack_wait, rdy_wait;
    bit          spurious, req_active, prev_ack;
    bit          prev_accept, prev_accept_first, prev_accept_last, line_over;
    logic [15:0] hold_addr;
    int          done_cnt, one_done_cnt;
    logic [15:0] rec_addr [32][4];
    logic [1:0]  rec_attr;

    vec_t        vecs [4];
    vec_t        v_hand;
    vec_t        v_rst;
    bit          found;

    bg_tile_fetch_sequencer #(.TILES_PER_LINE(TPL)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_line(start_line), .line_row(line_row),
        .bg_pt_sel(bg_pt_sel), .fetch_pixel_row(fetch_pixel_row),
        .fetch_pixel_col(fetch_pixel_col), .nametable_ptr(nametable_ptr),
        .pattern_table_offset(pattern_table_offset), .vram_req(vram_req),
        .vram_addr(vram_addr), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
        .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_pat_lo(tile_pat_lo),
        .tile_pat_hi(tile_pat_hi), .tile_attr(tile_attr), .busy(busy),
        .line_done(line_done)
    );

    bg_tile_fetch_sequencer #(.TILES_PER_LINE(1)) u_one (
        .clk(clk), .rst_n(rst_n), .start_line(start_line), .line_row(line_row),
        .bg_pt_sel(bg_pt_sel), .fetch_pixel_row(one_pixel_row),
        .fetch_pixel_col(one_pixel_col), .nametable_ptr(nametable_ptr),
        .pattern_table_offset(pattern_table_offset), .vram_req(one_vram_req),
        .vram_addr(one_vram_addr), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
        .tile_valid(one_tile_valid), .tile_ready(tile_ready), .tile_pat_lo(one_pat_lo),
        .tile_pat_hi(one_pat_hi), .tile_attr(one_attr), .busy(one_busy),
        .line_done(one_line_done)
    );

    // Pointer-calc stand-in: coarse row and coarse column into a
    // 32-tile-wide nametable, fine row as the pattern offset.
    assign nametable_ptr        = nt_base | {6'b0, fetch_pixel_row[7:3], fetch_pixel_col[7:3]};
    assign pattern_table_offset = fetch_pixel_row[2:0];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_data(input logic [15:0] a);
        if (ov_en && a == ov_nt_addr) return ov_nt_data;
        if (ov_en && a == ov_at_addr) return ov_at_data;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    function automatic int kind_of(input int k);
`ifdef BG_ATTR_FETCH_EN
        return k;
`else
        return (k == 0) ? KIND_NT : k + 1;
`endif
    endfunction

    function automatic logic [15:0] nt_model();
        return exp_base | {6'b0, exp_row[7:3], 5'(exp_n)};
    endfunction

    function automatic logic [15:0] exp_addr(input int k);
        logic [15:0] nt;
        nt = nt_model();
        case (kind_of(k))
            KIND_NT:  return nt;
            KIND_AT:  return {4'h2, nt[11:10], 4'hF, nt[9:7], nt[4:2]};
            KIND_PLO: return {3'b000, exp_sel, exp_idx, 1'b0, exp_row[2:0]};
            default:  return {3'b000, exp_sel, exp_idx, 1'b1, exp_row[2:0]};
        endcase
    endfunction

    function automatic logic [1:0] attr_model();
`ifdef BG_ATTR_FETCH_EN
        logic [15:0] nt;
        logic [7:0]  t;
        int          sh;
        nt = nt_model();
        sh = (nt[6] ? 4 : 0) + (nt[1] ? 2 : 0);
        t  = exp_at >> sh;
        return t[1:0];
`else
        return 2'b00;
`endif
    endfunction

    task automatic model_capture(input logic [7:0] d);
        tile_t t;
        case (kind_of(exp_k))
            KIND_NT:  exp_idx = d;
            KIND_AT:  exp_at  = d;
            KIND_PLO: exp_lo  = d;
            default: begin
                t.lo   = exp_lo;
                t.hi   = d;
                t.attr = attr_model();
                tile_q.push_back(t);
            end
        endcase
        exp_k = (exp_k + 1) % NF;
    endtask

    // One negedge worth of checking and input driving.
    task automatic cycle_step();
        bit accept_now;
        bit ack_now;
        accept_now = 0;
        ack_now    = 0;
        if (line_done) done_cnt++;
        if (one_line_done) one_done_cnt++;
        if (prev_accept_last) begin
            check_output("line_done_pulse", 32'(line_done), 1);
            check_output("busy_after_line", 32'(busy), 0);
            line_over = 1;
        end
        if (prev_accept_first) check_output("one_line_done", 32'(one_line_done), 1);
        if (prev_accept && !prev_accept_last) check_output("fetch_resume", 32'(vram_req), 1);
        if (prev_ack) check_output("req_gap", 32'(vram_req), 0);

        vram_ack   = 1'b0;
        vram_rdata = 8'h00;
        if (vram_req) begin
            if (!req_active) begin
                req_active = 1;
                ack_wait   = 0;
                hold_addr  = vram_addr;
                check_output("fetch_addr", 32'(vram_addr), 32'(exp_addr(exp_k)));
                check_output("pixel_row", 32'(fetch_pixel_row), 32'(exp_row));
                check_output("pixel_col", 32'(fetch_pixel_col), exp_n * 8);
                if (exp_n == 0) begin
                    check_output("one_req", 32'(one_vram_req), 1);
                    check_output("one_addr", 32'(one_vram_addr), 32'(exp_addr(exp_k)));
                end
                if (exp_n < 32) rec_addr[exp_n][exp_k] = vram_addr;
            end else begin
                check_output("addr_hold", 32'(vram_addr), 32'(hold_addr));
            end
            check_output("fetch_while_valid", 32'(tile_valid), 0);
            if (ack_wait >= ack_dly) begin
                vram_ack   = 1'b1;
                vram_rdata = mem_data(hold_addr);
                model_capture(vram_rdata);
                req_active = 0;
                ack_now    = 1;
            end else begin
                ack_wait++;
            end
        end else begin
            if (req_active) check_output("req_held", 32'(vram_req), 1);
            if (spurious) begin
                vram_ack   = 1'b1;
                vram_rdata = 8'hFF;
            end
        end

        tile_ready = spurious;
        if (tile_valid) begin
            check_output("stall_no_req", 32'(vram_req), 0);
            if (tile_q.size() == 0) begin
                check_output("tile_expected", 0, 1);
            end else begin
                check_output("tile_pat_lo", 32'(tile_pat_lo), 32'(tile_q[0].lo));
                check_output("tile_pat_hi", 32'(tile_pat_hi), 32'(tile_q[0].hi));
                check_output("tile_attr", 32'(tile_attr), 32'(tile_q[0].attr));
            end
            if (rdy_wait >= rdy_dly) begin
                tile_ready = 1'b1;
                accept_now = 1;
                rdy_wait   = 0;
            end else begin
                tile_ready = 1'b0;
                rdy_wait++;
            end
        end
        prev_accept       = accept_now;
        prev_accept_first = accept_now && exp_n == 0;
        prev_accept_last  = accept_now && exp_n == TPL - 1;
        if (accept_now) begin
            if (tile_q.size() > 0) void'(tile_q.pop_front());
            if (exp_n == 5) rec_attr = tile_attr;
            exp_n++;
        end
        prev_ack   = ack_now;
        start_line = spurious && exp_n == 0 && vram_req;
        if (start_line) line_row = 9'd200;
    endtask

    task automatic begin_line(input vec_t v);
        exp_row  = v.row;
        exp_sel  = v.sel;
        exp_base = v.base;
        ack_dly  = v.ack_dly;
        rdy_dly  = v.rdy_dly;
        spurious = v.spurious;
        exp_n = 0; exp_k = 0;
        tile_q.delete();
        req_active = 0; prev_ack = 0; prev_accept = 0;
        prev_accept_first = 0; prev_accept_last = 0;
        rdy_wait = 0; done_cnt = 0; one_done_cnt = 0; line_over = 0;
        @(negedge clk);
        nt_base    = v.base;
        bg_pt_sel  = v.sel;
        line_row   = v.row;
        start_line = 1'b1;
        @(negedge clk);
        start_line = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        begin_line(v);
        for (int c = 0; c < 4000 && !line_over; c++) begin
            cycle_step();
            if (!line_over) @(negedge clk);
        end
        if (!line_over) check_output("line_timeout", 0, 1);
        start_line = 1'b0;
        tile_ready = 1'b0;
        vram_ack   = 1'b0;
        @(negedge clk);
        if (line_done) done_cnt++;
        check_output("line_done_count", done_cnt, v.exp_done);
        check_output("one_done_count", one_done_cnt, 1);
        check_output("tile_queue_empty", tile_q.size(), 0);
        check_output("one_busy_idle", 32'(one_busy), 0);
        check_output("busy_idle", 32'(busy), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_req"}, 32'(vram_req), 0);
        check_output({tag, "_addr"}, 32'(vram_addr), 0);
        check_output({tag, "_valid"}, 32'(tile_valid), 0);
        check_output({tag, "_tile"}, {14'b0, tile_attr, tile_pat_hi, tile_pat_lo}, 0);
        check_output({tag, "_busy"}, 32'(busy), 0);
        check_output({tag, "_done"}, 32'(line_done), 0);
        check_output({tag, "_pixel"}, {14'b0, fetch_pixel_row, fetch_pixel_col}, 0);
        check_output({tag, "_one"}, {30'b0, one_busy, one_vram_req}, 0);
    endtask

    // Main sequence: reset state, table of whole lines, the row-17 tile
    // with known bytes, then a reset in the middle of a pattern fetch.
    initial begin
        vecs[0] = '{9'd0,   1'b0, 16'h2000, 0, 0,  1'b0, 16'h2000, 16'h23C0, 1};
        vecs[1] = '{9'd17,  1'b1, 16'h2400, 0, 0,  1'b0, 16'h2440, 16'h27C0, 1};
        vecs[2] = '{9'd100, 1'b0, 16'h2000, 3, 0,  1'b1, 16'h2180, 16'h23D8, 1};
        vecs[3] = '{9'd239, 1'b1, 16'h2800, 1, 10, 1'b0, 16'h2BA0, 16'h2BF8, 1};
        v_hand  = '{9'd17,  1'b1, 16'h2000, 0, 0,  1'b0, 16'h2040, 16'h23C0, 1};
        v_rst   = '{9'd9,   1'b0, 16'h2000, 3, 0,  1'b0, 16'h2020, 16'h23C0, 1};

        rst_n = 1'b0; start_line = 1'b0; line_row = 9'd0; bg_pt_sel = 1'b0;
        vram_ack = 1'b0; vram_rdata = 8'h00; tile_ready = 1'b0; nt_base = 16'h2000;
        ov_en = 0; ov_nt_addr = 16'h2045; ov_nt_data = 8'h3C;
        ov_at_addr = 16'h23C1; ov_at_data = 8'hD4; rec_attr = 2'b00;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            $display("[TB] line vector %0d row=%0d", i, vecs[i].row);
            apply_stimulus(vecs[i]);
            check_output("tile0_nt_addr", 32'(rec_addr[0][0]), 32'(vecs[i].exp_nt0));
`ifdef BG_ATTR_FETCH_EN
            check_output("tile0_at_addr", 32'(rec_addr[0][1]), 32'(vecs[i].exp_at0));
`endif
        end

        $display("[TB] row 17 tile 5 with fixed bytes");
        ov_en = 1;
        apply_stimulus(v_hand);
        ov_en = 0;
        check_output("t5_nt_addr", 32'(rec_addr[5][0]), 32'h2045);
`ifdef BG_ATTR_FETCH_EN
        check_output("t5_at_addr", 32'(rec_addr[5][1]), 32'h23C1);
        check_output("t5_attr", 32'(rec_attr), 32'h1);
`else
        check_output("t5_attr", 32'(rec_attr), 32'h0);
`endif
        check_output("t5_plo_addr", 32'(rec_addr[5][K_PLO]), 32'h13C1);
        check_output("t5_phi_addr", 32'(rec_addr[5][K_PHI]), 32'h13C9);

        $display("[TB] reset during pattern fetch");
        begin_line(v_rst);
        found = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            cycle_step();
            if (vram_req && req_active && exp_n == 1 && exp_k == K_PLO) found = 1;
            else @(negedge clk);
        end
        check_output("reset_reached_plo", 32'(found), 1);
        vram_ack   = 1'b1;
        vram_rdata = 8'h77;
        tile_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("pending_ack_busy", 32'(busy), 0);
        check_output("pending_ack_req", 32'(vram_req), 0);
        vram_ack = 1'b0;
        apply_stimulus(v_rst);
        check_output("post_reset_tile0", 32'(rec_addr[0][0]), 32'(v_rst.exp_nt0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
